// File: rtl/pipeline_interlock.sv
// Stall/flush controller beside decode: tracks in-flight register writers and drives
// stall, flush, bubble and PC-select controls. Optional counters: INTERLOCK_PERF_EN.
module pipeline_interlock #(
  parameter int unsigned NREG         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_valid,
  input  logic [4:0]      d_rs_a,
  input  logic [4:0]      d_rt_a,
  input  logic [4:0]      d_rd_a,
  input  logic            d_uses_rs,
  input  logic            d_uses_rt,
  input  logic            d_writes,
  input  logic            d_is_jump,
  input  logic            e_branch_taken,
  input  logic            wb_write,
  input  logic [4:0]      wb_dst,
  output logic            f_stall,
  output logic            d_stall,
  output logic            d_flush,
  output logic            e_bubble,
  output logic [1:0]      pc_sel,
  output logic [NREG-1:0] pending
`ifdef INTERLOCK_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StStall = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [1:0] PcSeq    = 2'd0;
  localparam logic [1:0] PcJump   = 2'd1;
  localparam logic [1:0] PcBranch = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic clr_rs, clr_rt, clr_rd;
  logic raw, waw, hazard, in_flush, issue;

  // A writeback to the same register this cycle satisfies the dependency via decode bypass.
  assign clr_rs = wb_write && (wb_dst == d_rs_a) && (d_rs_a != 5'd0);
  assign clr_rt = wb_write && (wb_dst == d_rt_a) && (d_rt_a != 5'd0);
  assign clr_rd = wb_write && (wb_dst == d_rd_a) && (d_rd_a != 5'd0);

  assign raw = d_valid &&
               ((d_uses_rs && (d_rs_a != 5'd0) && pending_q[d_rs_a] && !clr_rs) ||
                (d_uses_rt && (d_rt_a != 5'd0) && pending_q[d_rt_a] && !clr_rt));
  assign waw = d_valid && d_writes && (d_rd_a != 5'd0) && pending_q[d_rd_a] && !clr_rd;

  assign hazard   = raw || waw;
  assign in_flush = (state_q == StFlush);
  assign issue    = d_valid && !hazard && !e_branch_taken && !in_flush;

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_flush  = 1'b0;
    e_bubble = !issue;
    pc_sel   = PcSeq;
    state_d  = StRun;
    cnt_d    = cnt_q;
    // A branch arriving while already flushing is a protocol error and is dropped.
    if (in_flush) begin
      d_flush  = 1'b1;
      e_bubble = 1'b1;
      if (cnt_q <= 2'd1) begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end else begin
        state_d = StFlush;
        cnt_d   = cnt_q - 2'd1;
      end
    end else if (e_branch_taken) begin
      pc_sel   = PcBranch;
      d_flush  = 1'b1;
      e_bubble = 1'b1;
      cnt_d    = 2'(FLUSH_CYCLES - 1);
      state_d  = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else if (hazard) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
      state_d  = StStall;
    end else if (issue && d_is_jump) begin
      pc_sel  = PcJump;
      d_flush = 1'b1;
    end
  end

  // Clear before set so a new writer to the retiring register keeps its bit.
  always_comb begin
    pending_d = pending_q;
    if (wb_write && (wb_dst != 5'd0)) pending_d[wb_dst] = 1'b0;
    if (issue && d_writes && (d_rd_a != 5'd0)) pending_d[d_rd_a] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      cnt_q     <= 2'd0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

`ifdef INTERLOCK_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (f_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (d_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: scripted cycle table, reset-during-flush sequence and a
// randomized run against a behavioural scoreboard model.
module tb_pipeline_interlock;

  localparam int NREG         = 32;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid, d_uses_rs, d_uses_rt, d_writes, d_is_jump;
  logic [4:0]  d_rs_a, d_rt_a, d_rd_a, wb_dst;
  logic        e_branch_taken, wb_write;
  logic        f_stall, d_stall, d_flush, e_bubble;
  logic [1:0]  pc_sel;
  logic [31:0] pending;
  logic [5:0]  outs;
`ifdef INTERLOCK_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  assign outs = {f_stall, d_stall, d_flush, e_bubble, pc_sel};

  always #5 clk = ~clk;

  pipeline_interlock #(
    .NREG        (NREG),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .d_valid       (d_valid),
    .d_rs_a        (d_rs_a),
    .d_rt_a        (d_rt_a),
    .d_rd_a        (d_rd_a),
    .d_uses_rs     (d_uses_rs),
    .d_uses_rt     (d_uses_rt),
    .d_writes      (d_writes),
    .d_is_jump     (d_is_jump),
    .e_branch_taken(e_branch_taken),
    .wb_write      (wb_write),
    .wb_dst        (wb_dst),
    .f_stall       (f_stall),
    .d_stall       (d_stall),
    .d_flush       (d_flush),
    .e_bubble      (e_bubble),
    .pc_sel        (pc_sel),
    .pending       (pending)
`ifdef INTERLOCK_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_cycles  (flush_cycles)
`endif
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, wr, jmp, br, wbw;
    logic [4:0] wbd;
    logic [5:0] exp_out;   // {f_stall, d_stall, d_flush, e_bubble, pc_sel}
    logic [31:0] exp_pend; // scoreboard after the edge
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    d_valid = t.v; d_rs_a = t.rs; d_rt_a = t.rt; d_rd_a = t.rd;
    d_uses_rs = t.urs; d_uses_rt = t.urt; d_writes = t.wr; d_is_jump = t.jmp;
    e_branch_taken = t.br; wb_write = t.wbw; wb_dst = t.wbd;
  endtask

  task automatic idle();
    d_valid = 0; d_rs_a = 0; d_rt_a = 0; d_rd_a = 0; d_uses_rs = 0; d_uses_rt = 0;
    d_writes = 0; d_is_jump = 0; e_branch_taken = 0; wb_write = 0; wb_dst = 0;
  endtask

  // Behavioural model state
  bit busy [NREG];
  int flush_left;
  int m_stalls, m_flushes;

  function automatic logic [31:0] busy_vec();
    logic [31:0] r = '0;
    for (int i = 1; i < NREG; i++) r[i] = busy[i];
    return r;
  endfunction

  vec_t tbl [16];

  initial begin
    vec_t t;
    logic [5:0] eo;
    bit in_fl, hz, iss;
    bit clr_rs, clr_rt, clr_rd;

    //         v  rs rt rd urs urt wr jmp br wbw wbd  out        pend
    tbl[0]  = '{1, 1, 5, 5, 1, 0, 1, 0, 0, 0, 0, 6'b000000, 32'h20};   // LW r5
    tbl[1]  = '{1, 5, 6, 8, 1, 1, 1, 0, 0, 0, 0, 6'b110100, 32'h20};   // ADD uses r5: stall
    tbl[2]  = '{1, 5, 6, 8, 1, 1, 1, 0, 0, 0, 0, 6'b110100, 32'h20};
    tbl[3]  = '{1, 5, 6, 8, 1, 1, 1, 0, 0, 1, 5, 6'b000000, 32'h100};  // wb r5 bypass
    tbl[4]  = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 8, 6'b000000, 32'h0};    // rd=0 not tracked
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 32'h0};    // rs=0 never stalls
    tbl[6]  = '{1, 2, 3, 4, 1, 1, 1, 0, 1, 0, 0, 6'b001110, 32'h0};    // branch taken
    tbl[7]  = '{1, 2, 3, 4, 1, 1, 1, 0, 0, 0, 0, 6'b001100, 32'h0};    // flush cycle
    tbl[8]  = '{1, 2, 3, 4, 1, 1, 1, 0, 0, 0, 0, 6'b000000, 32'h10};   // back in RUN
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b001001, 32'h10};   // jump
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b001110, 32'h10};   // jump + branch
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 6'b001100, 32'h0};    // branch in FLUSH ignored
    tbl[12] = '{1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 32'h80};   // writer r7
    tbl[13] = '{1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 6'b110100, 32'h80};   // WAW stall
    tbl[14] = '{1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 7, 6'b000000, 32'h80};   // set wins over clear
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 6'b000100, 32'h0};

    idle();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'h04);
    check("reset_pending", pending, 32'h0);
    reset = 1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tbl[i].exp_out));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_pend", i), pending, tbl[i].exp_pend);
    end

    // Reset while flushing with r5 and r7 in flight
    t = '{1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 6'b0, 32'h0};
    @(negedge clk); apply(t);
    t.rd = 7;
    @(negedge clk); apply(t);
    @(negedge clk); idle(); e_branch_taken = 1;
    @(negedge clk); idle();
    #1;
    check("rst_flush_pend_before", pending, 32'hA0);
    check("rst_flush_dflush_before", 32'(d_flush), 32'h1);
    reset = 0;
    #1;
    check("rst_flush_pend", pending, 32'h0);
    check("rst_flush_outs", 32'(outs), 32'h04);
`ifdef INTERLOCK_PERF_EN
    check("rst_stall_cnt", stall_cycles, 32'h0);
    check("rst_flush_cnt", flush_cycles, 32'h0);
`endif
    @(negedge clk);
    reset = 1;
    t.rd = 3;
    apply(t);
    #1;
    check("after_rst_issue_outs", 32'(outs), 32'h00);
    @(posedge clk); #1;
    check("after_rst_pend", pending, 32'h08);

    // Randomized run against the model
    @(negedge clk); idle(); reset = 0;
    @(negedge clk); reset = 1;
    for (int i = 0; i < NREG; i++) busy[i] = 0;
    flush_left = 0; m_stalls = 0; m_flushes = 0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      d_valid = ($urandom_range(0, 3) != 0);
      d_rs_a = 5'($urandom_range(0, 7));
      d_rt_a = 5'($urandom_range(0, 7));
      d_rd_a = 5'($urandom_range(0, 7));
      d_uses_rs = 1'($urandom); d_uses_rt = 1'($urandom); d_writes = 1'($urandom);
      d_is_jump = ($urandom_range(0, 5) == 0);
      e_branch_taken = ($urandom_range(0, 9) == 0);
      wb_write = 1'($urandom);
      wb_dst = 5'($urandom_range(0, 7));
      #1;

      clr_rs = wb_write && wb_dst == d_rs_a && d_rs_a != 0;
      clr_rt = wb_write && wb_dst == d_rt_a && d_rt_a != 0;
      clr_rd = wb_write && wb_dst == d_rd_a && d_rd_a != 0;
      hz = d_valid && ((d_uses_rs && d_rs_a != 0 && busy[d_rs_a] && !clr_rs) ||
                       (d_uses_rt && d_rt_a != 0 && busy[d_rt_a] && !clr_rt) ||
                       (d_writes && d_rd_a != 0 && busy[d_rd_a] && !clr_rd));
      in_fl = (flush_left > 0);
      iss = d_valid && !hz && !e_branch_taken && !in_fl;

      if (in_fl) begin
        eo = 6'b001100;
        flush_left--;
      end else if (e_branch_taken) begin
        eo = 6'b001110;
        flush_left = FLUSH_CYCLES - 1;
      end else if (hz) begin
        eo = 6'b110100;
      end else if (iss && d_is_jump) begin
        eo = 6'b001001;
      end else begin
        eo = iss ? 6'b000000 : 6'b000100;
      end

      check($sformatf("rnd%0d_outs", cyc), 32'(outs), 32'(eo));
      check($sformatf("rnd%0d_pend", cyc), pending, busy_vec());

      if (eo[5]) m_stalls++;
      if (eo[3]) m_flushes++;
      if (wb_write && wb_dst != 0) busy[wb_dst] = 0;
      if (iss && d_writes && d_rd_a != 0) busy[d_rd_a] = 1;
    end

    @(posedge clk); #1;
    check("rnd_final_pend", pending, busy_vec());
`ifdef INTERLOCK_PERF_EN
    check("rnd_stall_cnt", stall_cycles, 32'(m_stalls));
    check("rnd_flush_cnt", flush_cycles, 32'(m_flushes));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
